// File: rtl/lsu_bus_bridge.sv
// Load/store bridge from an RV32I MEM stage to a valid/ready data bus.
// Builds word-aligned requests with byte strobes, extends load data and stalls the core until completion.
module lsu_bus_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [2:0]            i_funct3,
    input  logic [DATA_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_stall,
    output logic                  o_misalign,
    output logic                  o_bus_err,
    output logic                  o_bus_valid,
    input  logic                  i_bus_ready,
    output logic                  o_bus_we,
    output logic [DATA_WIDTH-1:0] o_bus_addr,
    output logic [3:0]            o_bus_wstrb,
    output logic [DATA_WIDTH-1:0] o_bus_wdata,
    input  logic                  i_bus_rvalid,
    input  logic [DATA_WIDTH-1:0] i_bus_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    function automatic logic access_legal(input logic we, input logic [2:0] f3, input logic [1:0] lane);
        logic ok;
        ok = 1'b0;
        case (f3)
            3'd0:    ok = 1'b1;
            3'd1:    ok = (lane[0] == 1'b0);
            3'd2:    ok = (lane == 2'b00);
            3'd4:    ok = !we;
            3'd5:    ok = !we && (lane[0] == 1'b0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lane);
        logic [3:0] strb;
        strb = 4'b0000;
        case (f3[1:0])
            2'd0:    strb = 4'b0001 << lane;
            2'd1:    strb = lane[1] ? 4'b1100 : 4'b0011;
            2'd2:    strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        w = 32'h0000_0000;
        case (f3[1:0])
            2'd0:    w = {4{d[7:0]}};
            2'd1:    w = {2{d[15:0]}};
            2'd2:    w = d;
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane, input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'h00;
        r = 32'h0000_0000;
        case (lane)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            2'd3:    b = d[31:24];
            default: b = 8'h00;
        endcase
        h = lane[1] ? d[31:16] : d[15:0];
        case (f3)
            3'd0:    r = {{24{b[7]}}, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd2:    r = d;
            3'd4:    r = {24'h00_0000, b};
            3'd5:    r = {16'h0000, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    state_t      state_r, next_state_s;
    logic [31:0] addr_r;
    logic [1:0]  lane_r;
    logic        we_r;
    logic [2:0]  funct3_r;
    logic [3:0]  wstrb_r;
    logic [31:0] wdata_r;
    logic [7:0]  cnt_r;
    logic [31:0] rdata_r;
    logic        err_r;

    logic legal_s, stall_s, misalign_s, latch_s, cnt_clr_s;
    logic rdata_upd_s, rdata_zero_s, err_set_s;

    assign legal_s = access_legal(i_we, i_funct3, i_addr[1:0]);

    // Next-state and per-cycle control decode.
    always_comb begin
        next_state_s = state_r;
        stall_s      = 1'b0;
        misalign_s   = 1'b0;
        latch_s      = 1'b0;
        cnt_clr_s    = 1'b0;
        rdata_upd_s  = 1'b0;
        rdata_zero_s = 1'b0;
        err_set_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_req) begin
                    if (legal_s) begin
                        next_state_s = REQ;
                        stall_s      = 1'b1;
                        latch_s      = 1'b1;
                        cnt_clr_s    = 1'b1;
                    end else begin
                        misalign_s   = 1'b1;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            REQ: begin
                stall_s = 1'b1;
                if (i_bus_ready) begin
                    cnt_clr_s    = 1'b1;
                    next_state_s = we_r ? DONE : WAIT_R;
                end else if (cnt_r == TMO_LAST) begin
                    next_state_s = DONE;
                    err_set_s    = 1'b1;
                    rdata_zero_s = !we_r;
                end else begin
                    next_state_s = REQ;
                end
            end
            WAIT_R: begin
                stall_s = 1'b1;
                if (i_bus_rvalid) begin
                    rdata_upd_s  = 1'b1;
                    next_state_s = DONE;
                end else if (cnt_r == TMO_LAST) begin
                    next_state_s = DONE;
                    err_set_s    = 1'b1;
                    rdata_zero_s = 1'b1;
                end else begin
                    next_state_s = WAIT_R;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, latched request, timeout counter and load result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            addr_r   <= 32'h0000_0000;
            lane_r   <= 2'b00;
            we_r     <= 1'b0;
            funct3_r <= 3'd0;
            wstrb_r  <= 4'b0000;
            wdata_r  <= 32'h0000_0000;
            cnt_r    <= 8'd0;
            rdata_r  <= 32'h0000_0000;
            err_r    <= 1'b0;
        end else begin
            state_r <= next_state_s;
            err_r   <= err_set_s;
            if (latch_s) begin
                addr_r   <= {i_addr[31:2], 2'b00};
                lane_r   <= i_addr[1:0];
                we_r     <= i_we;
                funct3_r <= i_funct3;
                wstrb_r  <= i_we ? store_strb(i_funct3, i_addr[1:0]) : 4'b0000;
                wdata_r  <= i_we ? store_data(i_funct3, i_wdata) : 32'h0000_0000;
            end
            // Counter restarts on every entry into REQ or WAIT_R.
            if (cnt_clr_s) begin
                cnt_r <= 8'd0;
            end else if ((state_r == REQ) || (state_r == WAIT_R)) begin
                cnt_r <= cnt_r + 8'd1;
            end else begin
                cnt_r <= 8'd0;
            end
            if (rdata_upd_s) begin
                rdata_r <= load_extend(funct3_r, lane_r, i_bus_rdata);
            end else if (rdata_zero_s) begin
                rdata_r <= 32'h0000_0000;
            end
        end
    end

    assign o_stall     = stall_s;
    assign o_misalign  = misalign_s;
    assign o_bus_err   = err_r;
    assign o_rdata     = rdata_r;
    assign o_bus_valid = (state_r == REQ);
    assign o_bus_we    = we_r;
    assign o_bus_addr  = addr_r;
    assign o_bus_wstrb = wstrb_r;
    assign o_bus_wdata = wdata_r;

endmodule
